mac_array_engine: RTL and testbench

//  Parametrised successor of the fixed 4-lane X-buffer/coefficient-ROM/ALU/writeback path.

---
 rtl/mac_array_if.sv | 37 +++
 rtl/mac_array_engine.sv | 167 ++++++++++++++++
 tb/tb_mac_array_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_if.sv
// Bundle of the job-control, sample-stream, coefficient-ROM and result
// ports of mac_array_engine. The master side drives the job; the slave side is the engine.
interface mac_array_if #(
   parameter int X_W    = 8,
   parameter int A_W    = 7,
   parameter int K      = 4,
   parameter int N_CH   = 4,
   parameter int ACC_W  = 18,
   parameter int ADDR_W = 8
);
   localparam int KW = $clog2(K);

   logic                    start;
   logic [ADDR_W-1:0]       base_addr;
   logic                    abort;
   logic                    x_valid;
   logic [X_W-1:0]          x_data;
   logic                    x_ready;
   logic [KW-1:0]           coef_addr;
   logic [N_CH*A_W-1:0]     coef_data;
   logic                    res_valid;
   logic                    res_ready;
   logic [N_CH*ACC_W-1:0]   res_data;
   logic [ADDR_W-1:0]       res_addr;
   logic                    busy;
   logic                    done;

   modport master (
      output start, base_addr, abort, x_valid, x_data, coef_data, res_ready,
      input  x_ready, coef_addr, res_valid, res_data, res_addr, busy, done
   );

   modport slave (
      input  start, base_addr, abort, x_valid, x_data, coef_data, res_ready,
      output x_ready, coef_addr, res_valid, res_data, res_addr, busy, done
   );
endinterface

// File: rtl/mac_array_engine.sv
// Column-wise matrix-vector engine: buffers K samples per column, multiplies them by a
// K-column coefficient ROM across N_CH lanes and streams one result word per column.
module mac_array_engine #(
   parameter int X_W    = 8,
   parameter int A_W    = 7,
   parameter int K      = 4,
   parameter int N_CH   = 4,
   parameter int N_COL  = 4,
   parameter int ACC_W  = 18,
   parameter int ADDR_W = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   mac_array_if.slave  bus
);
   localparam int KW   = $clog2(K);
   localparam int CW   = $clog2(K + 1);
   localparam int COLW = (N_COL > 1) ? $clog2(N_COL) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_DONE} state_t;

   state_t            state;
   logic [KW-1:0]     n;
   logic [CW-1:0]     mac_cnt;
   logic [COLW-1:0]   col;
   logic [ADDR_W-1:0] addr;
   logic [X_W-1:0]    xbuf [K];
   logic [ACC_W-1:0]  acc  [N_CH];
   logic              x_ready_q;
   logic              res_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [KW-1:0]     coef_addr_q;

   logic [KW-1:0]     tap;
   logic [ACC_W-1:0]  sum [N_CH];
   logic              x_hs;
   logic              res_hs;

   function automatic logic [ACC_W-1:0] ext_x(input logic [X_W-1:0] v);
      if (SIGNED) return {{(ACC_W-X_W){v[X_W-1]}}, v};
      return {{(ACC_W-X_W){1'b0}}, v};
   endfunction

   function automatic logic [ACC_W-1:0] ext_a(input logic [A_W-1:0] v);
      if (SIGNED) return {{(ACC_W-A_W){v[A_W-1]}}, v};
      return {{(ACC_W-A_W){1'b0}}, v};
   endfunction

   assign x_hs   = bus.x_valid & x_ready_q;
   assign res_hs = res_valid_q & bus.res_ready;

   // MAC cycle j consumes ROM column j-1 (read issued one cycle earlier) against xbuf[j-1].
   // Operands are extended to ACC_W first, so the truncated product is exact in both modes.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign every output before use, so no latch is inferred.
      tap = KW'(mac_cnt - CW'(1));
      for (int i = 0; i < N_CH; i++) begin
         sum[i] = acc[i] + ext_x(xbuf[tap]) * ext_a(bus.coef_data[i*A_W +: A_W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state updates use non-blocking '<=' so every register samples pre-edge values.
      if (rst) begin
         state       <= S_IDLE;
         n           <= '0;
         mac_cnt     <= '0;
         col         <= '0;
         addr        <= '0;
         x_ready_q   <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         coef_addr_q <= '0;
         // NOTE: the sample buffer is a handful of flops, not a RAM macro, so it is reset with the rest.
         for (int k = 0; k < K; k++) xbuf[k] <= '0;
         for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end else if (bus.abort) begin
         state       <= S_IDLE;
         n           <= '0;
         mac_cnt     <= '0;
         col         <= '0;
         addr        <= '0;
         x_ready_q   <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         coef_addr_q <= '0;
         for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state     <= S_LOAD;
                  col       <= '0;
                  n         <= '0;
                  addr      <= bus.base_addr;
                  x_ready_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_LOAD: begin
               if (x_hs) begin
                  xbuf[n] <= bus.x_data;
                  n       <= n + KW'(1);
                  if (n == KW'(K - 1)) begin
                     state       <= S_MAC;
                     n           <= '0;
                     x_ready_q   <= 1'b0;
                     mac_cnt     <= '0;
                     coef_addr_q <= '0;
                     for (int i = 0; i < N_CH; i++) acc[i] <= '0;
                  end
               end
            end
            S_MAC: begin
               mac_cnt     <= mac_cnt + CW'(1);
               coef_addr_q <= (mac_cnt < CW'(K - 1)) ? KW'(mac_cnt + CW'(1)) : '0;
               if (mac_cnt != '0) begin
                  for (int i = 0; i < N_CH; i++) acc[i] <= sum[i];
               end
               if (mac_cnt == CW'(K)) begin
                  state       <= S_WB;
                  mac_cnt     <= '0;
                  res_valid_q <= 1'b1;
               end
            end
            S_WB: begin
               if (res_hs) begin
                  res_valid_q <= 1'b0;
                  if (col == COLW'(N_COL - 1)) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state     <= S_LOAD;
                     col       <= col + COLW'(1);
                     addr      <= addr + ADDR_W'(1);
                     n         <= '0;
                     x_ready_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.x_ready   = x_ready_q;
   assign bus.coef_addr = coef_addr_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_addr  = addr;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_res
      assign bus.res_data[i*ACC_W +: ACC_W] = acc[i];
   end
endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine: an unsigned 4-column instance and a signed
// 1-column instance share one stimulus set; 'sel' picks which one is started and observed.
module tb_mac_array_engine;
   localparam int X_W = 8, A_W = 7, K = 4, N_CH = 4, ACC_W = 18, ADDR_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0, abort = 1'b0, x_valid = 1'b0, res_ready = 1'b0, sel = 1'b0;
   logic [7:0] base_addr = '0, x_data = '0;

   mac_array_if #(.X_W(X_W), .A_W(A_W), .K(K), .N_CH(N_CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_if ();
   mac_array_if #(.X_W(X_W), .A_W(A_W), .K(K), .N_CH(N_CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) s_if ();

   assign u_if.start     = start & ~sel;
   assign s_if.start     = start & sel;
   assign u_if.base_addr = base_addr;
   assign s_if.base_addr = base_addr;
   assign u_if.abort     = abort;
   assign s_if.abort     = abort;
   assign u_if.x_valid   = x_valid;
   assign s_if.x_valid   = x_valid;
   assign u_if.x_data    = x_data;
   assign s_if.x_data    = x_data;
   assign u_if.res_ready = res_ready;
   assign s_if.res_ready = res_ready;

   mac_array_engine #(.X_W(X_W), .A_W(A_W), .K(K), .N_CH(N_CH), .N_COL(4), .ACC_W(ACC_W),
                      .ADDR_W(ADDR_W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(u_if.slave));
   mac_array_engine #(.X_W(X_W), .A_W(A_W), .K(K), .N_CH(N_CH), .N_COL(1), .ACC_W(ACC_W),
                      .ADDR_W(ADDR_W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));

   logic        x_ready, res_valid, busy, done;
   logic [1:0]  coef_addr;
   logic [71:0] res_data;
   logic [7:0]  res_addr;
   assign x_ready   = sel ? s_if.x_ready   : u_if.x_ready;
   assign res_valid = sel ? s_if.res_valid : u_if.res_valid;
   assign busy      = sel ? s_if.busy      : u_if.busy;
   assign done      = sel ? s_if.done      : u_if.done;
   assign coef_addr = sel ? s_if.coef_addr : u_if.coef_addr;
   assign res_data  = sel ? s_if.res_data  : u_if.res_data;
   assign res_addr  = sel ? s_if.res_addr  : u_if.res_addr;

   // Coefficient ROMs with one cycle of read latency.
   logic [27:0] rom_u [4];
   logic [27:0] rom_s [4];
   always @(posedge clk) begin
      u_if.coef_data <= rom_u[u_if.coef_addr];
      s_if.coef_data <= rom_s[s_if.coef_addr];
   end

   int n_checks = 0, n_pass = 0, n_fail = 0, done_seen = 0;
   logic [7:0]  xv [4][4];
   logic [71:0] ev [4];

   always @(negedge clk) if (done) done_seen++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] lanes(input int l3, input int l2, input int l1, input int l0);
      return {l3[17:0], l2[17:0], l1[17:0], l0[17:0]};
   endfunction

   task automatic check_idle(input string tag);
      check($sformatf("%s_busy", tag), busy, 1'b0);
      check($sformatf("%s_res_valid", tag), res_valid, 1'b0);
      check($sformatf("%s_x_ready", tag), x_ready, 1'b0);
      check($sformatf("%s_done", tag), done, 1'b0);
      check($sformatf("%s_coef_addr", tag), coef_addr, 2'd0);
      check($sformatf("%s_res_data", tag), res_data, 72'd0);
      check($sformatf("%s_res_addr", tag), res_addr, 8'd0);
   endtask

   task automatic send_x(input logic [7:0] v, input int gap, input string tag);
      int t;
      repeat (gap) tick();
      x_valid = 1'b1;
      x_data  = v;
      t = 0;
      while (!x_ready && t < 50) begin
         tick();
         t++;
      end
      if (!x_ready) check($sformatf("%s_x_ready_wait", tag), x_ready, 1'b1);
      tick();
      x_valid = 1'b0;
   endtask

   task automatic run_job(input logic [7:0] base, input int gap, input int stall, input int ncol,
                          input string tag);
      int d0;
      d0 = done_seen;
      base_addr = base;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("%s_busy_start", tag), busy, 1'b1);
      for (int c = 0; c < ncol; c++) begin
         for (int k = 0; k < 4; k++) send_x(xv[c][k], gap, tag);
         check($sformatf("%s_c%0d_xrdy_mac", tag, c), x_ready, 1'b0);
         check($sformatf("%s_c%0d_caddr0", tag, c), coef_addr, 2'd0);
         tick();
         check($sformatf("%s_c%0d_caddr1", tag, c), coef_addr, 2'd1);
         repeat (3) tick();
         check($sformatf("%s_c%0d_valid_early", tag, c), res_valid, 1'b0);
         tick();
         check($sformatf("%s_c%0d_valid", tag, c), res_valid, 1'b1);
         for (int s = 0; s < stall; s++) begin
            tick();
            check($sformatf("%s_c%0d_hold_valid", tag, c), res_valid, 1'b1);
            check($sformatf("%s_c%0d_hold_data", tag, c), res_data, ev[c]);
            check($sformatf("%s_c%0d_hold_xrdy", tag, c), x_ready, 1'b0);
         end
         check($sformatf("%s_c%0d_data", tag, c), res_data, ev[c]);
         check($sformatf("%s_c%0d_addr", tag, c), res_addr, 8'(base + 8'(c)));
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
      end
      check($sformatf("%s_done_pulse", tag), done, 1'b1);
      tick();
      check($sformatf("%s_done_low", tag), done, 1'b0);
      check($sformatf("%s_busy_end", tag), busy, 1'b0);
      check($sformatf("%s_done_count", tag), done_seen - d0, 1);
   endtask

   initial begin
      int d0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b0;
      tick();

      // A[i][k] = i+1
      for (int k = 0; k < 4; k++) rom_u[k] = {7'd4, 7'd3, 7'd2, 7'd1};
      for (int k = 0; k < 4; k++) begin
         xv[0][k] = 8'(k + 1);
         xv[1][k] = 8'd0;
         xv[2][k] = (k == 0) ? 8'd5 : ((k == 3) ? 8'd1 : 8'd0);
         xv[3][k] = 8'd255;
      end
      ev[0] = lanes(40, 30, 20, 10);
      ev[1] = lanes(0, 0, 0, 0);
      ev[2] = lanes(24, 18, 12, 6);
      ev[3] = lanes(4080, 3060, 2040, 1020);
      run_job(8'h10, 0, 0, 4, "basic");
      run_job(8'h10, 2, 0, 4, "gapped");

      // Full-scale unsigned operands, stalled writeback, address wrap.
      for (int k = 0; k < 4; k++) rom_u[k] = {4{7'd127}};
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) xv[c][k] = 8'd255;
         ev[c] = lanes(129540, 129540, 129540, 129540);
      end
      run_job(8'hFE, 0, 5, 4, "maxwrap");

      // Signed instance.
      sel = 1'b1;
      for (int k = 0; k < 4; k++) rom_s[k] = {4{7'h40}};
      for (int k = 0; k < 4; k++) xv[0][k] = 8'h80;
      ev[0] = lanes(32768, 32768, 32768, 32768);
      run_job(8'h20, 0, 0, 1, "sneg");
      for (int k = 0; k < 4; k++) rom_s[k] = {4{7'h3F}};
      ev[0] = lanes(-32256, -32256, -32256, -32256);
      run_job(8'h21, 0, 0, 1, "smix");
      sel = 1'b0;

      // Abort in the middle of the MAC phase.
      d0 = done_seen;
      for (int k = 0; k < 4; k++) rom_u[k] = {7'd4, 7'd3, 7'd2, 7'd1};
      base_addr = 8'h33;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) send_x(8'(k + 1), 0, "abort");
      repeat (2) tick();
      check("abort_in_mac_busy", busy, 1'b1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_idle("abort");
      repeat (3) tick();
      check("abort_still_idle", busy, 1'b0);
      check("abort_no_done", done_seen - d0, 0);

      // Asynchronous reset while a result is waiting.
      base_addr = 8'h50;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) send_x(8'(k + 1), 0, "rstwb");
      repeat (5) tick();
      check("rstwb_valid", res_valid, 1'b1);
      check("rstwb_data", res_data, lanes(40, 30, 20, 10));
      #2 rst = 1'b1;
      #1;
      check_idle("rstwb");
      #2 rst = 1'b0;
      tick();
      check("rstwb_after_busy", busy, 1'b0);
      check("rstwb_no_done", done_seen - d0, 0);

      // Column-dependent coefficients after recovery: A[i][k] = (i+1)*(k+1).
      for (int k = 0; k < 4; k++)
         rom_u[k] = {7'(4 * (k + 1)), 7'(3 * (k + 1)), 7'(2 * (k + 1)), 7'(k + 1)};
      for (int k = 0; k < 4; k++) begin
         xv[0][k] = 8'(k + 1);
         xv[1][k] = 8'(4 - k);
         xv[2][k] = (k == 3) ? 8'd9 : 8'd0;
         xv[3][k] = (k == 0) ? 8'd7 : 8'd0;
      end
      ev[0] = lanes(120, 90, 60, 30);
      ev[1] = lanes(80, 60, 40, 20);
      ev[2] = lanes(144, 108, 72, 36);
      ev[3] = lanes(28, 21, 14, 7);
      run_job(8'h40, 1, 1, 4, "recover");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
